// File: rtl/ysyx_23060203_inst_queue.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060203_inst_queue
// Description : In-order instruction queue between fetch and decode. Accepts
//               {pc,inst} pairs over valid/ready, buffers up to DEPTH entries
//               and presents the oldest one to decode. A flush empties the
//               queue in a single cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_23060203_inst_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clock,
  input  logic          reset,      // asynchronous, active-low
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_pc,
  input  logic [31:0]   in_inst,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_inst,
  output logic [AW:0]   count
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        alive;        // low during reset and until the first edge after it
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic [63:0] mem [DEPTH];
  logic [63:0] head;

  // Occupancy flags and handshakes; in_ready deliberately ignores out_ready
  // so there is no combinational path from decode back to fetch.
  always_comb begin
    empty     = (wr_ptr == rd_ptr);
    full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    in_ready  = alive & ~full & ~flush;
    out_valid = ~empty & ~flush;
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
    count     = wr_ptr - rd_ptr;
  end

  // Head entry is read straight out of the array (no output register).
  always_comb begin
    head     = mem[rd_ptr[AW-1:0]];
    out_pc   = head[63:32];
    out_inst = head[31:0];
  end

  // Storage array: written on push only, never reset.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {in_pc, in_inst};
    end
  end

  // Pointer and start-up state. Flush wins over everything: the read pointer
  // jumps to the write pointer, discarding all buffered entries.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      alive  <= 1'b0;
    end else begin
      alive <= 1'b1;
      if (flush) begin
        rd_ptr <= wr_ptr;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060203_inst_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_23060203_inst_queue
// Description : Scoreboard bench for the instruction queue. Accepted pushes
//               are queued as expected output; the monitor compares every
//               presented head entry and the status outputs each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060203_inst_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_inst = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [AW:0] count;

  int total = 0;
  int bad   = 0;

  logic [63:0] sb[$];       // expected {pc,inst} in order
  logic        tb_alive;    // an edge has passed since reset release

  ysyx_23060203_inst_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .count     (count)
  );

  // 10 time-unit clock
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue accepts from the first edge after reset is released
  always @(posedge clock or negedge reset) begin
    if (!reset) tb_alive <= 1'b0;
    else        tb_alive <= 1'b1;
  end

  // Monitor / scoreboard, sampled mid-cycle
  always @(negedge clock) begin
    logic exp_ir;
    logic exp_ov;
    if (!reset) begin
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      sb.delete();
    end else begin
      exp_ir = tb_alive && (sb.size() < DEPTH) && !flush;
      exp_ov = (sb.size() > 0) && !flush;
      chk("count", 64'(count), 64'(sb.size()));
      chk("in_ready", 64'(in_ready), 64'(exp_ir));
      chk("out_valid", 64'(out_valid), 64'(exp_ov));
      if (exp_ov) chk("head", {out_pc, out_inst}, sb[0]);
      if (flush) begin
        sb.delete();
      end else begin
        if (exp_ov && out_ready) void'(sb.pop_front());
        if (in_valid && exp_ir)  sb.push_back({in_pc, in_inst});
      end
    end
  end

  // Apply inputs for one cycle, return 1 time unit after the next posedge
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                      input logic ordy, input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_inst   = ins;
    out_ready = ordy;
    flush     = fl;
    @(posedge clock);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    step(0, 0, 0, 0, 0);

    // Fill to full with decode stalled
    for (int i = 0; i < 4; i++) step(1, 32'h8000_0000 + 32'(4 * i), 32'h100 + 32'(i), 0, 0);
    in_valid = 1'b0;
    #1;
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_in_ready", 64'(in_ready), 64'd0);
    chk("fill_head_pc", 64'(out_pc), 64'h8000_0000);

    // Full: push attempt blocked even though a pop happens
    step(1, 32'h8000_0010, 32'h104, 1, 0);
    chk("full_pop_count", 64'(count), 64'd3);
    chk("full_pop_pc", 64'(out_pc), 64'h8000_0004);
    step(1, 32'h8000_0010, 32'h104, 0, 0);
    chk("retry_count", 64'(count), 64'd4);
    repeat (4) step(0, 0, 0, 1, 0);
    chk("drained", 64'(count), 64'd0);

    // Streaming at one per cycle through several pointer wraps
    for (int i = 0; i < 12; i++) step(1, 32'h8000_0000 + 32'(4 * i), 32'(i), 1, 0);
    chk("stream_count", 64'(count), 64'd1);
    chk("stream_last_pc", 64'(out_pc), 64'h8000_002C);
    step(0, 0, 0, 1, 0);

    // Flush with three entries and a competing push
    for (int i = 0; i < 3; i++) step(1, 32'h9000_0000 + 32'(4 * i), 32'h200 + 32'(i), 0, 0);
    step(1, 32'hDEAD_0000, 32'hDEAD, 1, 1);
    chk("flush_count", 64'(count), 64'd0);
    step(1, 32'h8000_1000, 32'h300, 0, 0);
    chk("redirect_valid", 64'(out_valid), 64'd1);
    chk("redirect_pc", 64'(out_pc), 64'h8000_1000);
    step(0, 0, 0, 1, 0);

    // Asynchronous reset with two entries buffered
    for (int i = 0; i < 2; i++) step(1, 32'hA000_0000 + 32'(4 * i), 32'h400 + 32'(i), 0, 0);
    in_valid = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("async_count", 64'(count), 64'd0);
    chk("async_out_valid", 64'(out_valid), 64'd0);
    chk("async_in_ready", 64'(in_ready), 64'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    step(1, 32'hB000_0000, 32'h500, 0, 0);   // not yet ready
    step(1, 32'hB000_0000, 32'h500, 0, 0);   // accepted
    chk("post_rst_pc", 64'(out_pc), 64'hB000_0000);
    step(0, 0, 0, 1, 0);

    // Single push into empty queue: one cycle latency
    step(1, 32'h3000_0000, 32'h0000_0013, 0, 0);
    in_valid = 1'b0;
    #1;
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("lat_inst", 64'(out_inst), 64'h13);
    step(0, 0, 0, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 99) < 60), $urandom, $urandom,
           1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 99) < 4));
    end
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
